// File: rtl/serdes_align_pkg.sv
// Shared types and constants for the ADC frame-lane alignment controller.
package serdes_align_pkg;

   localparam int unsigned ADC_WORD_W = 14;
   localparam logic [ADC_WORD_W-1:0] DEFAULT_FRAME_PATTERN = 14'h3F80;

   typedef enum logic [2:0] {
      StIdle,
      StSrst,
      StSettle,
      StCheck,
      StSlip,
      StLocked,
      StFail
   } state_e;

endpackage

// File: rtl/serdes_frame_align_ctrl.sv
// Frame-lane alignment for a 1:14 DDR deserializer: reset, bitslip until the frame word
// matches, then hold lock and watch for loss of lock.
module serdes_frame_align_ctrl
   import serdes_align_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = ADC_WORD_W,
   parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
   parameter int unsigned RST_CYCLES = 8,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned MATCH_COUNT = 16,
   parameter int unsigned LOSS_COUNT = 4,
   parameter int unsigned MAX_SLIPS = 28,
   localparam int unsigned SlipW = $clog2(MAX_SLIPS + 1)
) (
   input  logic                  clkdiv,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] frame_q,
   output logic                  serdes_rst,
   output logic                  bitslip,
   output logic                  locked,
   output logic                  align_err,
   output logic [SlipW-1:0]      slip_count,
   output logic [7:0]            loss_events
);

   localparam int unsigned TimerMax = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TimerW = $clog2(TimerMax + 1);
   localparam int unsigned MatchW = $clog2(MATCH_COUNT + 1);
   localparam int unsigned LossW = $clog2(LOSS_COUNT + 1);

   state_e            state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [MatchW-1:0] match_q, match_d;
   logic [LossW-1:0]  loss_q, loss_d;
   logic [SlipW-1:0]  slip_q, slip_d;
   logic [7:0]        loss_ev_q, loss_ev_d;
   logic              serdes_rst_q, bitslip_q, locked_q, align_err_q;
   logic              frame_match;

   assign frame_match = (frame_q == FRAME_PATTERN);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      match_d   = match_q;
      loss_d    = loss_q;
      slip_d    = slip_q;
      loss_ev_d = loss_ev_q;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StSrst;
               timer_d = '0;
               slip_d  = '0;
               match_d = '0;
            end
            StSrst: begin
               if (timer_q == TimerW'(RST_CYCLES - 1)) begin
                  state_d = StSettle;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            StSettle: begin
               if (timer_q == TimerW'(SETTLE_CYCLES - 1)) begin
                  state_d = StCheck;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            StCheck: begin
               if (frame_match) begin
                  if (match_q == MatchW'(MATCH_COUNT - 1)) begin
                     state_d = StLocked;
                     match_d = '0;
                     loss_d  = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  match_d = '0;
                  if (slip_q == SlipW'(MAX_SLIPS)) begin
                     state_d = StFail;
                  end else begin
                     state_d = StSlip;
                     slip_d  = slip_q + 1'b1;
                  end
               end
            end
            StSlip: begin
               state_d = StSettle;
               timer_d = '0;
            end
            StLocked: begin
               if (frame_match) begin
                  loss_d = '0;
               end else if (loss_q == LossW'(LOSS_COUNT - 1)) begin
                  // Realign by re-checking only; the deserializer keeps its slip position.
                  state_d = StCheck;
                  loss_d  = '0;
                  match_d = '0;
                  slip_d  = '0;
                  if (loss_ev_q != 8'hFF) loss_ev_d = loss_ev_q + 8'd1;
               end else begin
                  loss_d = loss_q + 1'b1;
               end
            end
            StFail: ;
            default: state_d = StIdle;
         endcase
      end
   end

   // Outputs decode the next state so they change on the same edge as the state.
   always_ff @(posedge clkdiv) begin
      if (rst) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         match_q      <= '0;
         loss_q       <= '0;
         slip_q       <= '0;
         loss_ev_q    <= '0;
         serdes_rst_q <= 1'b1;
         bitslip_q    <= 1'b0;
         locked_q     <= 1'b0;
         align_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         match_q      <= match_d;
         loss_q       <= loss_d;
         slip_q       <= slip_d;
         loss_ev_q    <= loss_ev_d;
         serdes_rst_q <= (state_d == StIdle) || (state_d == StSrst);
         bitslip_q    <= (state_d == StSlip);
         locked_q     <= (state_d == StLocked);
         align_err_q  <= (state_d == StFail);
      end
   end

   assign serdes_rst  = serdes_rst_q;
   assign bitslip     = bitslip_q;
   assign locked      = locked_q;
   assign align_err   = align_err_q;
   assign slip_count  = slip_q;
   assign loss_events = loss_ev_q;

endmodule

// File: tb/tb_serdes_frame_align_ctrl.sv
// Bench for serdes_frame_align_ctrl: an ISERDES model rotating the frame word by slip index,
// a table of alignment scenarios checked through a scoreboard, and hand-written corner cases.
module tb_serdes_frame_align_ctrl;
   import serdes_align_pkg::*;

   logic        clkdiv = 1'b0;
   logic        rst;
   logic        enable;
   logic [13:0] frame_q;
   logic        serdes_rst, bitslip, locked, align_err;
   logic [4:0]  slip_count;
   logic [7:0]  loss_events;

   always #5 clkdiv = ~clkdiv;

   serdes_frame_align_ctrl dut (
      .clkdiv      (clkdiv),
      .rst         (rst),
      .enable      (enable),
      .frame_q     (frame_q),
      .serdes_rst  (serdes_rst),
      .bitslip     (bitslip),
      .locked      (locked),
      .align_err   (align_err),
      .slip_count  (slip_count),
      .loss_events (loss_events)
   );

   // ISERDES model: slip position resets with SERDES_RST, new alignment visible 2 cycles later.
   int offset = 0;
   bit bad = 1'b0;
   bit corrupt = 1'b0;
   int slip_idx = 0, idx_p1 = 0, idx_p2 = 0;
   int rot;

   function automatic logic [13:0] rotl(input logic [13:0] v, input int r);
      return (v << r) | (v >> (14 - r));
   endfunction

   always @(posedge clkdiv) begin
      if (serdes_rst) slip_idx <= 0;
      else if (bitslip) slip_idx <= slip_idx + 1;
      idx_p1 <= slip_idx;
      idx_p2 <= idx_p1;
   end

   always_comb begin
      rot = ((offset - idx_p2) % 14 + 14) % 14;
      if (bad || corrupt) frame_q = 14'h1555;
      else frame_q = rotl(DEFAULT_FRAME_PATTERN, rot);
   end

   // BITSLIP pulse monitor.
   int   cyc = 0, pulses = 0, last_pulse = -100, min_gap = 1000, gap_viol = 0, double_hi = 0;
   logic prev_bs = 1'b0;

   always @(negedge clkdiv) begin
      cyc     <= cyc + 1;
      prev_bs <= bitslip;
      if (bitslip) begin
         pulses     <= pulses + 1;
         last_pulse <= cyc;
         if (cyc - last_pulse < min_gap) min_gap <= cyc - last_pulse;
         if (cyc - last_pulse < 6) gap_viol <= gap_viol + 1;
         if (prev_bs) double_hi <= double_hi + 1;
      end
   end

   int passed = 0, total = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clkdiv);
   endtask

   // Called at a negedge with enable low; raises enable, measures reset length and outcome latency.
   task automatic start_align(output int lat, output int rst_hi);
      enable = 1'b1;
      @(posedge clkdiv);
      rst_hi = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clkdiv);
         if (k == 0) check("srst_slip_clear", slip_count, 0);
         if (serdes_rst) rst_hi++;
         else break;
      end
      lat = 0;
      while (!(locked || align_err) && lat < 400) begin
         @(negedge clkdiv);
         lat++;
      end
   endtask

   typedef struct {
      int offset;
      bit bad;
      bit exp_locked;
      bit exp_err;
      int exp_slips;
      int exp_lat;
   } vec_t;

   typedef struct {
      bit locked;
      bit err;
      int slips;
      int lat;
   } exp_t;

   vec_t vecs[4];
   exp_t sb[$];

   initial begin
      int   lat, rst_hi, p0, v0, timeouts, waited;
      exp_t e;

      // Lock latency after reset release: 4 settle + 16 checks + 6 cycles per slip.
      // Fail latency: 4 settle + 1 check + 28 * 6.
      vecs[0] = '{offset: 0,  bad: 1'b0, exp_locked: 1'b1, exp_err: 1'b0, exp_slips: 0,  exp_lat: 20};
      vecs[1] = '{offset: 5,  bad: 1'b0, exp_locked: 1'b1, exp_err: 1'b0, exp_slips: 5,  exp_lat: 50};
      vecs[2] = '{offset: 13, bad: 1'b0, exp_locked: 1'b1, exp_err: 1'b0, exp_slips: 13, exp_lat: 98};
      vecs[3] = '{offset: 0,  bad: 1'b1, exp_locked: 1'b0, exp_err: 1'b1, exp_slips: 28, exp_lat: 173};

      rst = 1'b1;
      enable = 1'b0;
      cycles(3);
      check("reset_serdes_rst", serdes_rst, 1);
      check("reset_bitslip", bitslip, 0);
      check("reset_locked", locked, 0);
      check("reset_align_err", align_err, 0);
      check("reset_slip_count", slip_count, 0);
      check("reset_loss_events", loss_events, 0);
      rst = 1'b0;
      cycles(2);

      for (int i = 0; i < 4; i++) begin
         offset = vecs[i].offset;
         bad    = vecs[i].bad;
         sb.push_back('{locked: vecs[i].exp_locked, err: vecs[i].exp_err,
                        slips: vecs[i].exp_slips, lat: vecs[i].exp_lat});
         p0 = pulses;
         v0 = gap_viol;
         start_align(lat, rst_hi);
         e = sb.pop_front();
         check($sformatf("v%0d_rst_cycles", i), rst_hi, 8);
         check($sformatf("v%0d_locked", i), locked, e.locked);
         check($sformatf("v%0d_align_err", i), align_err, e.err);
         check($sformatf("v%0d_slip_count", i), slip_count, e.slips);
         check($sformatf("v%0d_latency", i), lat, e.lat);
         check($sformatf("v%0d_pulses", i), pulses - p0, e.slips);
         check($sformatf("v%0d_gap_viol", i), gap_viol - v0, 0);
         enable = 1'b0;
         @(negedge clkdiv);
         check($sformatf("v%0d_idle_serdes_rst", i), serdes_rst, 1);
         check($sformatf("v%0d_idle_locked", i), locked, 0);
         check($sformatf("v%0d_idle_align_err", i), align_err, 0);
         check($sformatf("v%0d_idle_slip_hold", i), slip_count, e.slips);
         cycles(2);
      end
      bad = 1'b0;
      check("sb_empty", sb.size(), 0);

      // Loss of lock: 3 bad words tolerated, 4 drop lock and realign without reset.
      offset = 0;
      start_align(lat, rst_hi);
      check("loss_pre_locked", locked, 1);
      corrupt = 1'b1;
      cycles(3);
      corrupt = 1'b0;
      cycles(3);
      check("loss3_locked", locked, 1);
      check("loss3_events", loss_events, 0);
      corrupt = 1'b1;
      cycles(4);
      corrupt = 1'b0;
      check("loss4_locked", locked, 0);
      check("loss4_events", loss_events, 1);
      check("loss4_slip_count", slip_count, 0);
      check("loss4_serdes_rst", serdes_rst, 0);
      lat = 0;
      while (!locked && lat < 40) begin
         @(negedge clkdiv);
         lat++;
      end
      check("relock_latency", lat, 16);

      // Drive the loss counter past saturation.
      timeouts = 0;
      for (int n = 0; n < 258; n++) begin
         corrupt = 1'b1;
         cycles(4);
         corrupt = 1'b0;
         waited = 0;
         while (!locked && waited < 40) begin
            @(negedge clkdiv);
            waited++;
         end
         if (!locked) timeouts++;
      end
      check("relock_timeouts", timeouts, 0);
      check("loss_events_saturate", loss_events, 255);

      // RST during a BITSLIP pulse, then during SETTLE.
      enable = 1'b0;
      cycles(2);
      offset = 5;
      enable = 1'b1;
      waited = 0;
      while (!bitslip && waited < 200) begin
         @(negedge clkdiv);
         waited++;
      end
      check("rst_slip_seen", bitslip, 1);
      rst = 1'b1;
      @(negedge clkdiv);
      check("rst_slip_bitslip", bitslip, 0);
      check("rst_slip_serdes_rst", serdes_rst, 1);
      check("rst_slip_locked", locked, 0);
      check("rst_slip_align_err", align_err, 0);
      check("rst_slip_slip_count", slip_count, 0);
      check("rst_slip_loss_events", loss_events, 0);
      rst = 1'b0;
      waited = 0;
      while (serdes_rst && waited < 50) begin
         @(negedge clkdiv);
         waited++;
      end
      check("settle_reached", serdes_rst, 0);
      @(negedge clkdiv);
      rst = 1'b1;
      @(negedge clkdiv);
      check("rst_settle_serdes_rst", serdes_rst, 1);
      check("rst_settle_bitslip", bitslip, 0);
      check("rst_settle_slip_count", slip_count, 0);
      rst = 1'b0;
      enable = 1'b0;
      cycles(2);

      // ENABLE toggled mid-alignment: slip count held while idle, cleared by the restart.
      enable = 1'b1;
      waited = 0;
      while (slip_count != 5'd2 && waited < 200) begin
         @(negedge clkdiv);
         waited++;
      end
      check("toggle_two_slips", slip_count, 2);
      enable = 1'b0;
      @(negedge clkdiv);
      check("toggle_serdes_rst", serdes_rst, 1);
      check("toggle_bitslip", bitslip, 0);
      check("toggle_slip_hold", slip_count, 2);
      cycles(2);
      p0 = pulses;
      start_align(lat, rst_hi);
      check("toggle_rst_cycles", rst_hi, 8);
      check("toggle_locked", locked, 1);
      check("toggle_latency", lat, 50);
      check("toggle_slip_count", slip_count, 5);
      check("toggle_pulses", pulses - p0, 5);

      check("bitslip_double_high", double_hi, 0);
      check("bitslip_gap_viol", gap_viol, 0);
      check("bitslip_min_gap", min_gap, 6);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
